// File: rtl/iob_pcie_chnl_host.sv
// Host/engine end of the PCIe channel protocol: drives RX transactions toward user logic
// from a source stream and terminates user TX transactions into a sink stream.
module iob_pcie_chnl_host #(
  parameter int C_PCI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_start,
  input  logic [31:0]                 rx_len,
  input  logic [30:0]                 rx_off,
  input  logic                        rx_last,
  output logic                        rx_busy,
  output logic                        rx_done,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic                        PCIE_CHNL_RX,
  input  logic                        PCIE_CHNL_RX_ACK,
  output logic                        PCIE_CHNL_RX_LAST,
  output logic [31:0]                 PCIE_CHNL_RX_LEN,
  output logic [30:0]                 PCIE_CHNL_RX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA,
  output logic                        PCIE_CHNL_RX_DATA_VALID,
  input  logic                        PCIE_CHNL_RX_DATA_REN,
  input  logic                        PCIE_CHNL_TX,
  output logic                        PCIE_CHNL_TX_ACK,
  input  logic                        PCIE_CHNL_TX_LAST,
  input  logic [31:0]                 PCIE_CHNL_TX_LEN,
  input  logic [30:0]                 PCIE_CHNL_TX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_TX_DATA,
  input  logic                        PCIE_CHNL_TX_DATA_VALID,
  output logic                        PCIE_CHNL_TX_DATA_REN,
  output logic [C_PCI_DATA_WIDTH-1:0] sink_data,
  output logic                        sink_valid,
  output logic                        sink_last,
  input  logic                        sink_ready,
  output logic [31:0]                 tx_len_o,
  output logic [30:0]                 tx_off_o,
  output logic                        tx_last_o,
  output logic                        tx_done
);
  localparam logic [31:0] LP_WPB = 32'(C_PCI_DATA_WIDTH / 32);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rx_st_t;
  typedef enum logic [1:0] {T_IDLE, T_ACK, T_DATA} tx_st_t;

  rx_st_t      r_rx_st;
  tx_st_t      r_tx_st;
  logic [31:0] r_rem, r_trem, r_rx_len, r_tx_len;
  logic [30:0] r_rx_off, r_tx_off;
  logic        r_rx_last, r_tx_last, r_rx_done, r_tx_done;

  logic        w_rx_dat, w_rx_acc, w_rx_fin;
  logic        w_tx_dat, w_tx_acc, w_tx_fin;
  logic [31:0] w_rem_nxt, w_trem_nxt;

  // Remaining-word counters saturate at zero so an odd tail beat never wraps.
  assign w_rx_dat   = (r_rx_st == R_DATA);
  assign w_rx_acc   = w_rx_dat & src_valid & PCIE_CHNL_RX_DATA_REN;
  assign w_rx_fin   = (r_rem <= LP_WPB);
  assign w_rem_nxt  = w_rx_fin ? 32'd0 : r_rem - LP_WPB;

  assign w_tx_dat   = (r_tx_st == T_DATA);
  assign w_tx_acc   = w_tx_dat & PCIE_CHNL_TX_DATA_VALID & sink_ready;
  assign w_tx_fin   = (r_trem <= LP_WPB);
  assign w_trem_nxt = w_tx_fin ? 32'd0 : r_trem - LP_WPB;

  assign rx_busy                 = (r_rx_st != R_IDLE);
  assign rx_done                 = r_rx_done;
  assign PCIE_CHNL_RX            = rx_busy;
  assign PCIE_CHNL_RX_LAST       = r_rx_last;
  assign PCIE_CHNL_RX_LEN        = r_rx_len;
  assign PCIE_CHNL_RX_OFF        = r_rx_off;
  assign PCIE_CHNL_RX_DATA       = w_rx_dat ? src_data : '0;
  assign PCIE_CHNL_RX_DATA_VALID = w_rx_dat & src_valid;
  assign src_ready               = w_rx_dat & PCIE_CHNL_RX_DATA_REN;

  assign PCIE_CHNL_TX_ACK        = (r_tx_st == T_ACK);
  assign PCIE_CHNL_TX_DATA_REN   = w_tx_dat & sink_ready;
  assign sink_valid              = w_tx_dat & PCIE_CHNL_TX_DATA_VALID;
  assign sink_data               = w_tx_dat ? PCIE_CHNL_TX_DATA : '0;
  assign sink_last               = w_tx_dat & w_tx_fin;
  assign tx_len_o                = r_tx_len;
  assign tx_off_o                = r_tx_off;
  assign tx_last_o               = r_tx_last;
  assign tx_done                 = r_tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st   <= R_IDLE;
      r_rem     <= '0;
      r_rx_len  <= '0;
      r_rx_off  <= '0;
      r_rx_last <= 1'b0;
      r_rx_done <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_st)
        R_IDLE: if (rx_start && rx_len != 32'd0) begin
          r_rx_len  <= rx_len;
          r_rx_off  <= rx_off;
          r_rx_last <= rx_last;
          r_rem     <= rx_len;
          r_rx_st   <= R_REQ;
        end
        R_REQ: if (PCIE_CHNL_RX_ACK) r_rx_st <= R_DATA;
        R_DATA: if (w_rx_acc) begin
          r_rem <= w_rem_nxt;
          if (w_rx_fin) begin
            r_rx_st   <= R_IDLE;
            r_rx_done <= 1'b1;
          end
        end
        default: r_rx_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st   <= T_IDLE;
      r_trem    <= '0;
      r_tx_len  <= '0;
      r_tx_off  <= '0;
      r_tx_last <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_st)
        T_IDLE: if (PCIE_CHNL_TX) begin
          r_tx_len  <= PCIE_CHNL_TX_LEN;
          r_tx_off  <= PCIE_CHNL_TX_OFF;
          r_tx_last <= PCIE_CHNL_TX_LAST;
          r_trem    <= PCIE_CHNL_TX_LEN;
          r_tx_st   <= T_ACK;
        end
        // Zero-length transfers finish right after the single ACK cycle.
        T_ACK: begin
          if (r_trem == 32'd0) begin
            r_tx_st   <= T_IDLE;
            r_tx_done <= 1'b1;
          end else begin
            r_tx_st   <= T_DATA;
          end
        end
        T_DATA: if (w_tx_acc) begin
          r_trem <= w_trem_nxt;
          if (w_tx_fin) begin
            r_tx_st   <= T_IDLE;
            r_tx_done <= 1'b1;
          end
        end
        default: r_tx_st <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Scoreboard bench for iob_pcie_chnl_host: bench-side source, user RX/TX agents and a
// negedge monitor that pops expected beats as the DUT hands them over.
module tb_iob_pcie_chnl_host;
  localparam int W = 64;

  logic clk = 1'b0, rst = 1'b1;
  logic rx_start = 0, rx_last = 0, rx_busy, rx_done;
  logic [31:0] rx_len = '0;
  logic [30:0] rx_off = '0;
  logic [W-1:0] src_data = '0;
  logic src_valid = 0, src_ready;
  logic PCIE_CHNL_RX, PCIE_CHNL_RX_ACK = 0, PCIE_CHNL_RX_LAST;
  logic [31:0] PCIE_CHNL_RX_LEN;
  logic [30:0] PCIE_CHNL_RX_OFF;
  logic [W-1:0] PCIE_CHNL_RX_DATA;
  logic PCIE_CHNL_RX_DATA_VALID, PCIE_CHNL_RX_DATA_REN = 0;
  logic PCIE_CHNL_TX = 0, PCIE_CHNL_TX_ACK, PCIE_CHNL_TX_LAST = 0;
  logic [31:0] PCIE_CHNL_TX_LEN = '0;
  logic [30:0] PCIE_CHNL_TX_OFF = '0;
  logic [W-1:0] PCIE_CHNL_TX_DATA = '0;
  logic PCIE_CHNL_TX_DATA_VALID = 0, PCIE_CHNL_TX_DATA_REN;
  logic [W-1:0] sink_data;
  logic sink_valid, sink_last, sink_ready = 0;
  logic [31:0] tx_len_o;
  logic [30:0] tx_off_o;
  logic tx_last_o, tx_done;

  iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_len(rx_len), .rx_off(rx_off),
    .rx_last(rx_last), .rx_busy(rx_busy), .rx_done(rx_done), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .PCIE_CHNL_RX(PCIE_CHNL_RX),
    .PCIE_CHNL_RX_ACK(PCIE_CHNL_RX_ACK), .PCIE_CHNL_RX_LAST(PCIE_CHNL_RX_LAST),
    .PCIE_CHNL_RX_LEN(PCIE_CHNL_RX_LEN), .PCIE_CHNL_RX_OFF(PCIE_CHNL_RX_OFF),
    .PCIE_CHNL_RX_DATA(PCIE_CHNL_RX_DATA), .PCIE_CHNL_RX_DATA_VALID(PCIE_CHNL_RX_DATA_VALID),
    .PCIE_CHNL_RX_DATA_REN(PCIE_CHNL_RX_DATA_REN), .PCIE_CHNL_TX(PCIE_CHNL_TX),
    .PCIE_CHNL_TX_ACK(PCIE_CHNL_TX_ACK), .PCIE_CHNL_TX_LAST(PCIE_CHNL_TX_LAST),
    .PCIE_CHNL_TX_LEN(PCIE_CHNL_TX_LEN), .PCIE_CHNL_TX_OFF(PCIE_CHNL_TX_OFF),
    .PCIE_CHNL_TX_DATA(PCIE_CHNL_TX_DATA), .PCIE_CHNL_TX_DATA_VALID(PCIE_CHNL_TX_DATA_VALID),
    .PCIE_CHNL_TX_DATA_REN(PCIE_CHNL_TX_DATA_REN), .sink_data(sink_data),
    .sink_valid(sink_valid), .sink_last(sink_last), .sink_ready(sink_ready),
    .tx_len_o(tx_len_o), .tx_off_o(tx_off_o), .tx_last_o(tx_last_o), .tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic last; logic [W-1:0] data; } beat_t;
  beat_t rx_q[$], tx_q[$];

  int n_tests = 0, n_fail = 0;
  int rx_done_cnt = 0, tx_done_cnt = 0, tx_ack_cyc = 0, tx_ren_cyc = 0, tx_stall_cyc = 0;
  logic rx_fin_chk = 0, tx_fin_chk = 0;
  logic [31:0] exp_rx_len = '0;

  logic [W-1:0] src_mem[16], tx_mem[16];
  int src_n = 0, src_idx = 0, tx_n = 0, tx_idx = 0;
  int rx_hi = 0, sink_stall = 0;
  logic ren_tog = 0, ren_off = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Bench-side source stream: advances on its own valid/ready handshake.
  initial forever begin
    @(posedge clk);
    if (!rst && src_valid && src_ready) src_idx++;
    #1;
    src_valid = (src_idx < src_n);
    src_data  = (src_idx < src_n) ? src_mem[src_idx] : '0;
  end

  // User TX producer: advances on VALID & REN from the DUT.
  initial forever begin
    @(posedge clk);
    if (!rst && PCIE_CHNL_TX_DATA_VALID && PCIE_CHNL_TX_DATA_REN) tx_idx++;
    #1;
    PCIE_CHNL_TX_DATA_VALID = (tx_idx < tx_n);
    PCIE_CHNL_TX_DATA       = (tx_idx < tx_n) ? tx_mem[tx_idx] : '0;
  end

  // User RX agent (ACK two cycles after request, REN policy) and sink ready policy.
  initial forever begin
    @(posedge clk); #1;
    rx_hi = PCIE_CHNL_RX ? rx_hi + 1 : 0;
    PCIE_CHNL_RX_ACK = (rx_hi >= 2);
    PCIE_CHNL_RX_DATA_REN = ren_off ? 1'b0 : (ren_tog ? ~PCIE_CHNL_RX_DATA_REN : 1'b1);
    if (sink_stall > 0) begin sink_ready = 1'b0; sink_stall--; end
    else sink_ready = 1'b1;
  end

  initial forever begin
    beat_t b;
    @(negedge clk);
    if (rx_fin_chk) begin
      chk("rx_req_fall", PCIE_CHNL_RX, 0);
      chk("rx_done_pulse", rx_done, 1);
      rx_fin_chk = 0;
    end
    if (tx_fin_chk) begin
      chk("tx_done_pulse", tx_done, 1);
      tx_fin_chk = 0;
    end
    if (rx_done) rx_done_cnt++;
    if (tx_done) tx_done_cnt++;
    if (PCIE_CHNL_TX_ACK) tx_ack_cyc++;
    if (PCIE_CHNL_TX_DATA_REN) tx_ren_cyc++;
    if (PCIE_CHNL_TX_DATA_VALID && !PCIE_CHNL_TX_DATA_REN) tx_stall_cyc++;
    if (PCIE_CHNL_RX) chk("rx_len_hold", PCIE_CHNL_RX_LEN, exp_rx_len);
    if (!rst && PCIE_CHNL_RX_DATA_VALID && PCIE_CHNL_RX_DATA_REN) begin
      if (rx_q.size() == 0) chk("rx_extra_beat", 1, 0);
      else begin
        b = rx_q.pop_front();
        chk("rx_data", PCIE_CHNL_RX_DATA, b.data);
        if (b.last) rx_fin_chk = 1;
      end
    end
    if (!rst && sink_valid && sink_ready) begin
      if (tx_q.size() == 0) chk("tx_extra_beat", 1, 0);
      else begin
        b = tx_q.pop_front();
        chk("sink_data", sink_data, b.data);
        chk("sink_last", sink_last, b.last);
        if (b.last) tx_fin_chk = 1;
      end
    end
  end

  task automatic load_src(input int n, input int base);
    for (int i = 0; i < n; i++) src_mem[i] = W'(base + i);
    src_idx = 0; src_n = n;
    src_valid = (n > 0);
    src_data  = src_mem[0];
  endtask

  task automatic push_rx(input int n, input int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = W'(base + i); b.last = (i == n - 1);
      rx_q.push_back(b);
    end
  endtask

  task automatic rx_go(input logic [31:0] len, input logic [30:0] off, input logic last);
    tick();
    rx_start = 1; rx_len = len; rx_off = off; rx_last = last;
    tick();
    rx_start = 0;
  endtask

  task automatic tx_req(input logic [31:0] len, input logic [30:0] off, input logic last);
    PCIE_CHNL_TX = 1; PCIE_CHNL_TX_LEN = len; PCIE_CHNL_TX_OFF = off; PCIE_CHNL_TX_LAST = last;
  endtask

  // Waits for the ACK, then drops the request and starts supplying n beats.
  task automatic tx_after(input int n, input int base, input int stall);
    beat_t b;
    logic seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = PCIE_CHNL_TX_ACK;
    end
    chk("tx_ack_seen", seen, 1);
    tick();
    PCIE_CHNL_TX = 0;
    for (int i = 0; i < n; i++) begin
      tx_mem[i] = W'(base + i);
      b.data = W'(base + i); b.last = (i == n - 1);
      tx_q.push_back(b);
    end
    tx_idx = 0; tx_n = n;
    PCIE_CHNL_TX_DATA_VALID = (n > 0);
    PCIE_CHNL_TX_DATA = tx_mem[0];
    if (stall > 0) begin sink_ready = 0; sink_stall = stall - 1; end
  endtask

  task automatic tx_go(input logic [31:0] len, input logic [30:0] off, input logic last,
                       input int n, input int base, input int stall);
    tick();
    tx_req(len, off, last);
    tx_after(n, base, stall);
  endtask

  task automatic wait_q(input bit is_rx);
    logic to = 1;
    for (int i = 0; i < 200 && to; i++) begin
      @(negedge clk);
      if ((is_rx ? rx_q.size() : tx_q.size()) == 0) to = 0;
    end
    chk(is_rx ? "rx_timeout" : "tx_timeout", to, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0, d1, bad;
    logic seen;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_rx_req", PCIE_CHNL_RX, 0);
    chk("rst_rx_len", PCIE_CHNL_RX_LEN, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_tx_ack", PCIE_CHNL_TX_ACK, 0);
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_tx_len_o", tx_len_o, 0);
    chk("rst_dones", {rx_done, tx_done}, 0);

    // RX len 8: four full beats
    d0 = rx_done_cnt;
    load_src(4, 1); push_rx(4, 1); exp_rx_len = 8;
    rx_go(8, 31'h10, 1);
    wait_q(1);
    chk("rx1_done_cnt", rx_done_cnt - d0, 1);
    chk("rx1_src_used", src_idx, 4);
    chk("rx1_off", PCIE_CHNL_RX_OFF, 31'h10);
    chk("rx1_last", PCIE_CHNL_RX_LAST, 1);

    // RX len 5 with REN toggling and a stray rx_start mid-transfer
    d0 = rx_done_cnt; ren_tog = 1;
    load_src(4, 'h100); push_rx(3, 'h100); exp_rx_len = 5;
    rx_go(5, 31'h0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = PCIE_CHNL_RX_DATA_VALID; end
    chk("rx2_data_phase", seen, 1);
    tick(); rx_start = 1; rx_len = 8;
    tick(); rx_start = 0;
    wait_q(1);
    ren_tog = 0;
    repeat (3) @(negedge clk);
    chk("rx2_done_cnt", rx_done_cnt - d0, 1);
    chk("rx2_src_used", src_idx, 3);
    chk("rx2_idle", rx_busy, 0);

    // TX len 6: three beats, sink always ready
    d1 = tx_done_cnt; tx_ack_cyc = 0; tx_stall_cyc = 0;
    tx_go(6, 31'h0, 1, 3, 'hA0, 0);
    wait_q(0);
    chk("tx1_ack_cyc", tx_ack_cyc, 1);
    chk("tx1_done_cnt", tx_done_cnt - d1, 1);
    chk("tx1_len_o", tx_len_o, 6);
    chk("tx1_last_o", tx_last_o, 1);
    chk("tx1_off_o", tx_off_o, 0);
    chk("tx1_stalls", tx_stall_cyc, 0);

    // TX len 4 with sink stalled for 5 cycles
    d1 = tx_done_cnt; tx_stall_cyc = 0;
    tx_go(4, 31'h5, 0, 2, 'hB0, 5);
    wait_q(0);
    chk("tx2_stall_cyc", tx_stall_cyc, 5);
    chk("tx2_done_cnt", tx_done_cnt - d1, 1);
    chk("tx2_off_o", tx_off_o, 31'h5);

    // Zero-length TX and RX
    d0 = rx_done_cnt; d1 = tx_done_cnt; tx_ack_cyc = 0; tx_ren_cyc = 0;
    tx_go(0, 31'h0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("tx0_ack_cyc", tx_ack_cyc, 1);
    chk("tx0_done_cnt", tx_done_cnt - d1, 1);
    chk("tx0_ren_cyc", tx_ren_cyc, 0);
    rx_go(0, 31'h0, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (rx_busy || PCIE_CHNL_RX) bad++; end
    chk("rx0_no_req", bad, 0);
    chk("rx0_done_cnt", rx_done_cnt - d0, 0);

    // Reset while both directions are in their data phase
    ren_off = 1;
    load_src(4, 'h200); push_rx(4, 'h200); exp_rx_len = 8;
    rx_go(8, 31'h0, 0);
    tx_go(6, 31'h0, 0, 3, 'hC0, 60);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = PCIE_CHNL_RX_DATA_VALID && sink_valid; end
    chk("rst_mid_data_phase", seen, 1);
    d0 = rx_done_cnt; d1 = tx_done_cnt;
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("rstm_rx", {PCIE_CHNL_RX, rx_busy, PCIE_CHNL_RX_DATA_VALID, src_ready}, 0);
    chk("rstm_rx_len", PCIE_CHNL_RX_LEN, 0);
    chk("rstm_tx", {PCIE_CHNL_TX_ACK, PCIE_CHNL_TX_DATA_REN, sink_valid, sink_last}, 0);
    chk("rstm_tx_len_o", tx_len_o, 0);
    chk("rstm_dones", {rx_done, tx_done}, 0);
    rx_q.delete(); tx_q.delete();
    sink_stall = 0; ren_off = 0; src_n = 0; tx_n = 0;
    repeat (3) @(negedge clk);
    chk("rstm_no_done", (rx_done_cnt - d0) + (tx_done_cnt - d1), 0);
    rx_fin_chk = 0; tx_fin_chk = 0;

    // Simultaneous RX and TX start after reset
    d0 = rx_done_cnt; d1 = tx_done_cnt;
    load_src(2, 'h300); push_rx(2, 'h300); exp_rx_len = 4;
    tick();
    rx_start = 1; rx_len = 4; rx_off = 31'h7; rx_last = 1;
    tx_req(2, 31'h3, 1);
    tick(); rx_start = 0;
    tx_after(1, 'hD0, 0);
    wait_q(1);
    wait_q(0);
    chk("sim_rx_done", rx_done_cnt - d0, 1);
    chk("sim_tx_done", tx_done_cnt - d1, 1);
    chk("sim_tx_len_o", tx_len_o, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
